multicycle_control: RTL and testbench

Main control FSM for the multicycle datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath mux selects, the write enables and the 2-bit `OpALU` code consumed by the ALU control decoder. Memory accesses wait on a `mem_ready` handshake, so the block tolerates multi-cycle memory.

---
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control.sv | 144 ++++++++++++++
 tb/tb_multicycle_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control FSM and the datapath.
// Ports (signals):
//   opcode, mem_ready                 : datapath -> controller
//   PCWrite .. PCSource               : controller -> datapath (selects, enables)
//   state                             : controller -> observer (debug)
// Handshake: mem_ready is a completion strobe. A memory request (MemRead or
// MemWrite) stays asserted and stable every cycle until a cycle in which
// mem_ready=1; that cycle completes the access and the FSM advances.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] OpALU;
  logic [1:0] PCSource;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSource,
           state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSource,
           state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath. Sequences each instruction
// through fetch / decode / execute / memory / write-back and drives the
// datapath selects, write enables and the 2-bit OpALU code.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces state to FETCH
//   bus   : multicycle_control_if.master (opcode/mem_ready in, controls and
//           debug state out)
// Outputs are a combinational decode of the state register; only the FETCH
// IRWrite/PCWrite enables are additionally gated by mem_ready, and all
// write/request enables are held low while reset is high.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADDR   = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECUTE   = 4'd6,
    RCOMPLETE = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  state_t state_q;

  // State register and transition logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:     state_q <= bus.mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_q <= MEMADDR;
            OP_R:         state_q <= EXECUTE;
            OP_BEQ:       state_q <= BRANCH;
            OP_J:         state_q <= JUMP;
            default:      state_q <= FETCH;   // unknown opcode acts as NOP
          endcase
        end
        MEMADDR:   state_q <= (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:   state_q <= bus.mem_ready ? MEMWB : MEMREAD;
        MEMWB:     state_q <= FETCH;
        MEMWRITE:  state_q <= bus.mem_ready ? FETCH : MEMWRITE;
        EXECUTE:   state_q <= RCOMPLETE;
        RCOMPLETE: state_q <= FETCH;
        BRANCH:    state_q <= FETCH;
        JUMP:      state_q <= FETCH;
        default:   state_q <= FETCH;          // encodings 10-15 recover
      endcase
    end
  end

  // Output decode. Unlisted outputs default to 0 in every state.
  logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;

  always_comb begin
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.OpALU       = 2'b00;
    bus.PCSource    = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read    = 1'b1;
        bus.ALUSrcB = 2'b01;
        // IR and PC load only on the cycle the fetch completes.
        ir_write    = bus.mem_ready;
        pc_write    = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
      end
      MEMADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMREAD: begin
        mem_read    = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        reg_write    = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEMWRITE: begin
        mem_write   = 1'b1;
        bus.IorD    = 1'b1;
      end
      EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.OpALU   = 2'b10;
      end
      RCOMPLETE: begin
        reg_write   = 1'b1;
        bus.RegDst  = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.OpALU     = 2'b01;
        pc_write_cond = 1'b1;
        bus.PCSource  = 2'b01;
      end
      JUMP: begin
        pc_write     = 1'b1;
        bus.PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  // Reset suppresses every state-changing enable so an aborted instruction
  // cannot write anything in the reset cycle.
  assign bus.PCWrite     = pc_write      & ~reset;
  assign bus.PCWriteCond = pc_write_cond & ~reset;
  assign bus.MemRead     = mem_read      & ~reset;
  assign bus.MemWrite    = mem_write     & ~reset;
  assign bus.IRWrite     = ir_write      & ~reset;
  assign bus.RegWrite    = reg_write     & ~reset;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b001000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Vector: {state[3:0], PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
  //          IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
  //          ALUSrcB[1:0], OpALU[1:0], PCSource[1:0]}
  logic [19:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [5:0]  cur_op;

  // Expected outputs for a given state, taken from the state table.
  function automatic logic [19:0] model(input logic [3:0] st, input logic mr,
                                        input logic rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, opalu, pcsrc;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0;
    m2r = 0; rdst = 0; rw = 0; srca = 0; srcb = 2'b00; opalu = 2'b00;
    pcsrc = 2'b00;
    case (st)
      4'd0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd1: begin srcb = 2'b11; end
      4'd2: begin srca = 1; srcb = 2'b10; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; iord = 1; end
      4'd6: begin srca = 1; opalu = 2'b10; end
      4'd7: begin rw = 1; rdst = 1; end
      4'd8: begin srca = 1; opalu = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      4'd9: begin pcw = 1; pcsrc = 2'b10; end
      default: ;
    endcase
    if (rst) begin
      pcw = 0; pcwc = 0; mrd = 0; mwr = 0; irw = 0; rw = 0;
    end
    return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
            srcb, opalu, pcsrc};
  endfunction

  function automatic logic [19:0] sample();
    return {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.OpALU, bus.PCSource};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs at the falling edge, push the expected
  // vector, then check the DUT output 1 time unit later.
  task automatic step(input string tag, input logic mr, input logic rst,
                      input logic [3:0] st);
    logic [19:0] got_v;
    logic [19:0] exp_v;
    @(negedge clk);
    bus.mem_ready = mr;
    bus.opcode    = cur_op;
    reset         = rst;
    exp_q.push_back(model(st, mr, rst));
    #1;
    got_v = sample();
    exp_v = exp_q.pop_front();
    total++;
    assert (got_v === exp_v) else begin
      bad++;
      $error("FAIL %s: state=%0d observed=%h expected=%h (exp state %0d)",
             tag, bus.state, got_v, exp_v, st);
    end
  endtask

  // Full instruction starting in FETCH; stalls insert mem_ready=0 cycles.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input int fstall, input int mstall);
    cur_op = op;
    for (int i = 0; i < fstall; i++) step(tag, 1'b0, 1'b0, 4'd0);
    step(tag, 1'b1, 1'b0, 4'd0);
    step(tag, 1'b1, 1'b0, 4'd1);
    case (op)
      OP_LW: begin
        step(tag, 1'b1, 1'b0, 4'd2);
        for (int i = 0; i < mstall; i++) step(tag, 1'b0, 1'b0, 4'd3);
        step(tag, 1'b1, 1'b0, 4'd3);
        step(tag, 1'b1, 1'b0, 4'd4);
      end
      OP_SW: begin
        step(tag, 1'b1, 1'b0, 4'd2);
        for (int i = 0; i < mstall; i++) step(tag, 1'b0, 1'b0, 4'd5);
        step(tag, 1'b1, 1'b0, 4'd5);
      end
      OP_R: begin
        step(tag, 1'b1, 1'b0, 4'd6);
        step(tag, 1'b1, 1'b0, 4'd7);
      end
      OP_BEQ: step(tag, 1'b1, 1'b0, 4'd8);
      OP_J:   step(tag, 1'b1, 1'b0, 4'd9);
      default: ;
    endcase
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset         = 1'b1;
    cur_op        = OP_LW;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_LW;
    repeat (2) @(posedge clk);

    // Reset held: state 0, enables forced low even with mem_ready=1.
    step("reset_hold", 1'b1, 1'b1, 4'd0);

    run_instr("lw",        OP_LW,  0, 0);
    run_instr("rtype",     OP_R,   0, 0);
    run_instr("beq",       OP_BEQ, 0, 0);
    run_instr("jump",      OP_J,   0, 0);
    run_instr("sw_stall",  OP_SW,  0, 3);
    run_instr("fetch_stall", OP_SW, 3, 0);
    run_instr("nop_op",    OP_BAD, 0, 0);
    run_instr("lw_stall",  OP_LW,  2, 2);

    // Abort a load in MEMREAD with reset.
    cur_op = OP_LW;
    step("abort_seq", 1'b1, 1'b0, 4'd0);
    step("abort_seq", 1'b1, 1'b0, 4'd1);
    step("abort_seq", 1'b1, 1'b0, 4'd2);
    step("abort_wait", 1'b0, 1'b0, 4'd3);
    step("abort_reset", 1'b1, 1'b1, 4'd3);
    run_instr("after_abort", OP_R, 0, 0);

    // Randomised stall lengths on memory instructions.
    for (int k = 0; k < 4; k++) begin
      run_instr("lw_rand", OP_LW, $urandom_range(0, 3), $urandom_range(0, 3));
      run_instr("sw_rand", OP_SW, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    step("final_fetch", 1'b1, 1'b0, 4'd0);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
